// File: rtl/key_action_ctrl.sv
// Lane-runner control block: game-state FSM driven by Enter/Crash plus
// lane movement from arrow keys with saturating bounds and auto-repeat.
module key_action_ctrl #(
    parameter int NUM_LANES    = 3,
    parameter int START_LANE   = 1,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       EnterEn,
    input  logic       LeftEn,
    input  logic       RightEn,
    input  logic       Crash,
    output logic [1:0] Lane,
    output logic [1:0] GameState,
    output logic       StartPulse,
    output logic       LaneChanged
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_PLAY  = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_OVER  = 2'b11;

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [1:0]    START_L   = 2'(START_LANE);
    localparam logic [1:0]    LAST_L    = 2'(NUM_LANES - 1);
    localparam logic [CW-1:0] DELAY_M1  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_M1   = CW'(REPEAT_RATE - 1);

    logic          enter_q, left_q, right_q;
    logic [1:0]    state_q, state_d;
    logic [1:0]    lane_q, lane_d;
    logic          start_q, start_d;
    logic          changed_q, changed_d;
    logic          armed_q, armed_d;
    logic          rep_q, rep_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic enter_rise_s, left_rise_s, right_rise_s;
    logic stay_play_s, hold_one_s, move_s;

    assign enter_rise_s = EnterEn & ~enter_q;
    assign left_rise_s  = LeftEn  & ~left_q;
    assign right_rise_s = RightEn & ~right_q;
    assign stay_play_s  = (state_q == ST_PLAY) & ~Crash & ~enter_rise_s;
    assign hold_one_s   = LeftEn ^ RightEn;

    // Game-state transitions; Crash wins over Enter while playing
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enter_rise_s) begin
                    state_d = ST_PLAY;
                    start_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (Crash) begin
                    state_d = ST_OVER;
                end else if (enter_rise_s) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_PAUSE: begin
                if (enter_rise_s) begin
                    state_d = ST_PLAY;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_OVER: begin
                if (enter_rise_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Repeat scheduling: armed only by a fresh rise, so a key carried
    // through PAUSE or a two-key chord never resumes repeating on its own
    always_comb begin
        armed_d = armed_q;
        rep_d   = rep_q;
        cnt_d   = cnt_q;
        move_s  = 1'b0;
        if (!stay_play_s || !hold_one_s) begin
            armed_d = 1'b0;
            rep_d   = 1'b0;
            cnt_d   = '0;
        end else if (left_rise_s || right_rise_s) begin
            move_s  = 1'b1;
            armed_d = 1'b1;
            rep_d   = 1'b0;
            cnt_d   = '0;
        end else if (armed_q) begin
            if (cnt_q == (rep_q ? RATE_M1 : DELAY_M1)) begin
                move_s = 1'b1;
                rep_d  = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d  = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Lane update with saturation; blocked moves keep the cadence silently
    always_comb begin
        lane_d    = lane_q;
        changed_d = 1'b0;
        if (state_q == ST_IDLE && enter_rise_s) begin
            lane_d = START_L;
        end else if (move_s) begin
            if (LeftEn) begin
                if (lane_q != 2'd0) begin
                    lane_d    = lane_q - 2'd1;
                    changed_d = 1'b1;
                end else begin
                    lane_d    = lane_q;
                end
            end else begin
                if (lane_q != LAST_L) begin
                    lane_d    = lane_q + 2'd1;
                    changed_d = 1'b1;
                end else begin
                    lane_d    = lane_q;
                end
            end
        end else begin
            lane_d = lane_q;
        end
    end

    // State registers; key history resets high so held keys need a re-press
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            enter_q   <= 1'b1;
            left_q    <= 1'b1;
            right_q   <= 1'b1;
            state_q   <= ST_IDLE;
            lane_q    <= START_L;
            start_q   <= 1'b0;
            changed_q <= 1'b0;
            armed_q   <= 1'b0;
            rep_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            enter_q   <= EnterEn;
            left_q    <= LeftEn;
            right_q   <= RightEn;
            state_q   <= state_d;
            lane_q    <= lane_d;
            start_q   <= start_d;
            changed_q <= changed_d;
            armed_q   <= armed_d;
            rep_q     <= rep_d;
            cnt_q     <= cnt_d;
        end
    end

    assign Lane        = lane_q;
    assign GameState   = state_q;
    assign StartPulse  = start_q;
    assign LaneChanged = changed_q;

endmodule

// File: doc/key_action_ctrl.md
KEY_ACTION_CTRL -- requirements
Module: key_action_ctrl

Interface
REQ-001 SHALL provide parameter NUM_LANES, default 3, number of lanes (legal 2..4).
REQ-002 SHALL provide parameter START_LANE, default 1, lane loaded on reset and on game start (must be < NUM_LANES).
REQ-003 SHALL provide parameter REPEAT_DELAY, default 25000000, cycles from the initial move to the first auto-repeat move.
REQ-004 SHALL provide parameter REPEAT_RATE, default 5000000, cycles between subsequent auto-repeat moves.
REQ-005 CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-006 Resetn  input  1  asynchronous, active-low reset.
REQ-007 EnterEn  input  1  Enter key held level from the keyboard decoder, synchronous to CLOCK_50.
REQ-008 LeftEn  input  1  left-arrow held level, synchronous to CLOCK_50.
REQ-009 RightEn  input  1  right-arrow held level, synchronous to CLOCK_50.
REQ-010 Crash  input  1  collision level from game logic, synchronous to CLOCK_50.
REQ-011 Lane  output  2  current car lane, 0 = leftmost.
REQ-012 GameState  output  2  00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER.
REQ-013 StartPulse  output  1  one-cycle pulse on IDLE->PLAY.
REQ-014 LaneChanged  output  1  one-cycle pulse in the cycle after Lane changes value.

Function
REQ-015 SHALL register EnterEn, LeftEn and RightEn each cycle; rise = current input 1 and previous sample 0.
REQ-016 Every output and state register SHALL be updated by the clock edge that samples the triggering input, giving one-edge latency.
REQ-017 FSM: in IDLE, an Enter rise SHALL go to PLAY, load Lane = START_LANE and assert StartPulse for 1 cycle.
REQ-018 FSM: in PLAY, Crash = 1 SHALL go to OVER; else an Enter rise SHALL go to PAUSE. Crash takes priority over Enter in the same cycle.
REQ-019 FSM: in PAUSE, an Enter rise SHALL return to PLAY; Crash is ignored and Lane is frozen.
REQ-020 FSM: in OVER, an Enter rise SHALL go to IDLE; Lane holds its last value.
REQ-021 Lane moves SHALL occur only in PLAY and only in cycles where the FSM does not leave PLAY.
REQ-022 A Left rise with RightEn = 0 SHALL decrement Lane; a Right rise with LeftEn = 0 SHALL increment Lane.
REQ-023 Auto-repeat: while exactly one direction stays held after its initial move at edge E0, further moves SHALL occur at E0+REPEAT_DELAY, then every REPEAT_RATE cycles.
REQ-024 A repeat counter SHALL clear on any direction rise, on release, when both directions are held, and outside PLAY. Its width SHALL hold max(REPEAT_DELAY, REPEAT_RATE) without wrap.
REQ-025 With LeftEn = RightEn = 1, no move SHALL occur, including on a simultaneous rise of both.
REQ-026 Lane SHALL saturate at 0 and NUM_LANES-1; a blocked move SHALL NOT pulse LaneChanged and SHALL NOT break the repeat cadence.
REQ-027 Entering PAUSE while a direction is held SHALL stop repeats; on return to PLAY that direction moves again only after a new rise.
REQ-028 LaneChanged SHALL pulse exactly once per actual Lane change and never on the START_LANE load.

Reset
REQ-029 Resetn = 0 SHALL immediately force GameState = IDLE, Lane = START_LANE, StartPulse = 0, LaneChanged = 0 and repeat counter = 0.
REQ-030 Input previous-sample registers SHALL reset to 1, so a key held through reset must be released and pressed again to act.
REQ-031 Reset asserted mid-game or mid-repeat SHALL abort all activity with no residual pulse after release.

Verification (NUM_LANES = 3, START_LANE = 1, REPEAT_DELAY = 4, REPEAT_RATE = 2)
REQ-032 Enter pulse from IDLE -> GameState 01, Lane 1, StartPulse high for exactly 1 cycle; a second Enter pulse -> 10; a third -> 01.
REQ-033 In PLAY, hold LeftEn for 10 cycles -> Lane goes 1->0 at E0 and stays 0; LaneChanged pulses once.
REQ-034 In PLAY from lane 0, hold RightEn -> Lane 1 at E0, 2 at E0+4, and stays 2 at E0+6, E0+8; exactly 2 LaneChanged pulses.
REQ-035 In PLAY, Crash and an Enter rise in the same cycle -> GameState 11 next cycle; an Enter rise -> 00.
REQ-036 Hold LeftEn, then assert RightEn -> no further moves and counter cleared; release RightEn -> no move until a new Left rise.
REQ-037 Hold EnterEn across Resetn low->high -> GameState stays 00 until EnterEn falls and rises again.
